// File: rtl/ex_muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_pkg
//  Description : Shared constants and types for the RV32M iterative
//                multiply/divide unit (funct3 op codes, FSM state encoding,
//                widths and divide special-case results).
//  Revision    : 1.0  initial release
// ============================================================================
package ex_muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    // funct3 encodings of the M extension
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    // Architectural results for the divide corner cases
    localparam logic [XLEN-1:0] DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_t;

endpackage : ex_muldiv_pkg
`default_nettype wire

// File: rtl/ex_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_if
//  Description : EX-stage request/response bundle of the multiply/divide unit.
//                master = pipeline/hazard side, slave = ex_muldiv.
//  Ports       : flush, start, op[2:0], a[31:0], b[31:0]  (master -> slave)
//                stall, busy, done, result[31:0]           (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface ex_muldiv_if;
    import ex_muldiv_pkg::*;

    logic            flush;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output flush, start, op, a, b,
        input  stall, busy, done, result
    );

    modport slave (
        input  flush, start, op, a, b,
        output stall, busy, done, result
    );

endinterface : ex_muldiv_if
`default_nettype wire

// File: rtl/ex_muldiv_core.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_core
//  Description : One-bit-per-cycle datapath on unsigned magnitudes.
//                Multiply : shift-add, product in {o_hi, o_lo}.
//                Divide   : restoring, remainder in o_hi, quotient in o_lo.
//  Ports       : clk, rst        clock / synchronous active-high reset
//                i_load          initialise from i_mag_a / i_mag_b / i_is_div
//                i_step          perform one iteration
//                i_is_div        1 = divide, 0 = multiply
//                i_mag_a/i_mag_b operand magnitudes
//                o_hi/o_lo       accumulator halves
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_core
    import ex_muldiv_pkg::*;
(
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            i_load,
    input  wire logic            i_step,
    input  wire logic            i_is_div,
    input  wire logic [XLEN-1:0] i_mag_a,
    input  wire logic [XLEN-1:0] i_mag_b,
    output logic      [XLEN-1:0] o_hi,
    output logic      [XLEN-1:0] o_lo
);

    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_b;
    logic            r_is_div;

    // Multiply: add divisor-less multiplicand when the LSB of the multiplier
    // (which shifts out of r_lo) is set; the carry becomes the new top bit.
    logic [XLEN:0]   w_mul_sum;
    // Divide: partial remainder shifted left with the next dividend bit.
    logic [XLEN:0]   w_shift;
    logic            w_fits;
    logic [XLEN-1:0] w_sub;

    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    assign w_shift   = {r_hi, r_lo[XLEN-1]};
    assign w_fits    = (w_shift >= {1'b0, r_b});
    // Remainder stays below the divisor, so the difference fits in XLEN bits.
    assign w_sub     = w_shift[XLEN-1:0] - r_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
        end else if (i_load) begin
            r_hi     <= '0;
            r_lo     <= i_mag_a;
            r_b      <= i_mag_b;
            r_is_div <= i_is_div;
        end else if (i_step) begin
            if (r_is_div) begin
                // Dividend bits leave the top of r_lo while quotient bits
                // enter at the bottom.
                r_hi <= w_fits ? w_sub : w_shift[XLEN-1:0];
                r_lo <= {r_lo[XLEN-2:0], w_fits};
            end else begin
                r_hi <= w_mul_sum[XLEN:1];
                r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule : muldiv_core
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv
//  Description : Iterative RV32M multiply/divide unit for the EX stage.
//                Owns the FSM, iteration counter, operand sign handling,
//                divide special cases and the pipeline stall request.
//  Ports       : clk   rising-edge clock
//                rst   synchronous active-high reset
//                bus   ex_muldiv_if.slave (flush/start/op/a/b in,
//                      stall/busy/done/result out)
//  Revision    : 1.0  initial release
// ============================================================================
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst,
    ex_muldiv_if.slave  bus
);

    muldiv_state_t     r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic              r_neg_q;   // sign of product / quotient
    logic              r_neg_r;   // sign of remainder (follows a)
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    // ---------------------------------------------------------------- decode
    logic              w_sgn_a;
    logic              w_sgn_b;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_div0;
    logic              w_ovf;
    logic [XLEN-1:0]   w_spec_res;
    logic              w_accept;

    assign w_sgn_a = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                     (bus.op == OP_DIV)  || (bus.op == OP_REM);
    assign w_sgn_b = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    assign w_neg_a = w_sgn_a & bus.a[XLEN-1];
    assign w_neg_b = w_sgn_b & bus.b[XLEN-1];
    assign w_mag_a = w_neg_a ? (~bus.a + 1'b1) : bus.a;
    assign w_mag_b = w_neg_b ? (~bus.b + 1'b1) : bus.b;

    assign w_div0 = bus.op[2] && (bus.b == '0);
    assign w_ovf  = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                    (bus.a == INT_MIN) && (bus.b == {XLEN{1'b1}});
    // op[1] separates remainder ops (6,7) from quotient ops (4,5).
    assign w_spec_res = w_div0 ? (bus.op[1] ? bus.a : DIV0_Q)
                               : (bus.op[1] ? {XLEN{1'b0}} : INT_MIN);

    assign w_accept = (r_state == ST_IDLE) && bus.start && !bus.flush;

    // -------------------------------------------------------------- datapath
    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_lo;

    muldiv_core u_core (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_accept),
        .i_step   ((r_state == ST_CALC) && !bus.flush),
        .i_is_div (bus.op[2]),
        .i_mag_a  (w_mag_a),
        .i_mag_b  (w_mag_b),
        .o_hi     (w_hi),
        .o_lo     (w_lo)
    );

    // ------------------------------------------------------ sign correction
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_res;

    assign w_prod = r_neg_q ? (~{w_hi, w_lo} + 1'b1) : {w_hi, w_lo};
    assign w_quo  = r_neg_q ? (~w_lo + 1'b1) : w_lo;
    assign w_rem  = r_neg_r ? (~w_hi + 1'b1) : w_hi;

    always_comb begin
        w_fix_res = '0;
        case (r_op)
            OP_MUL:                      w_fix_res = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             w_fix_res = w_quo;
            OP_REM, OP_REMU:             w_fix_res = w_rem;
            default:                     w_fix_res = '0;
        endcase
    end

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_op     <= OP_MUL;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (bus.flush) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_neg_q <= w_neg_a ^ w_neg_b;
                        r_neg_r <= w_neg_a;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        if (w_div0 || w_ovf) begin
                            r_result <= w_spec_res;
                            r_state  <= ST_DONE;
                            r_done   <= 1'b1;
                        end else begin
                            r_state  <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == {CNT_W{1'b1}}) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_result <= w_fix_res;
                    r_state  <= ST_DONE;
                    r_done   <= 1'b1;
                end
                ST_DONE: begin
                    // start still belongs to the finishing instruction here
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stall  = w_accept || (r_state == ST_CALC) || (r_state == ST_FIX);
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule : ex_muldiv
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_muldiv
//  Description : Directed self-checking bench for ex_muldiv.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    logic [31:0] last_exp;

    ex_muldiv_if bus ();

    ex_muldiv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one M-op at the current negedge, hold start until done, then
    // release it. Returns at the negedge of the cycle following done.
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int exp_stall);
        int st;
        int dn;
        int first_done;
        st = 0;
        dn = 0;
        first_done = -1;
        bus.op = f;
        bus.a = x;
        bus.b = y;
        bus.start = 1'b1;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (bus.stall) st++;
            if (bus.done) begin
                dn++;
                if (first_done < 0) first_done = c;
                bus.start = 1'b0;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, " result"}, bus.result, exp);
        check({tag, " stall_cycles"}, st, exp_stall);
        check({tag, " done_pulses"}, dn, 1);
        check({tag, " done_latency"}, first_done, exp_stall);
        last_exp = exp;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        last_exp = 32'h0;
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.a = 32'h0;
        bus.b = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset busy",   {31'b0, bus.busy},  32'h0);
        check("reset done",   {31'b0, bus.done},  32'h0);
        check("reset stall",  {31'b0, bus.stall}, 32'h0);
        check("reset result", bus.result,         32'h0);
        @(negedge clk);

        // multiply family
        do_op("MUL 7*-3",       OP_MUL,    32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        do_op("MULHU ff*ff",    OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        do_op("MULH ff*ff",     OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
        do_op("MULHSU ff*ff",   OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);

        // divide family
        do_op("DIV -7/2",       OP_DIV,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 34);
        do_op("REM -7/2",       OP_REM,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 34);
        do_op("DIVU 100/7",     OP_DIVU,   32'd100,       32'd7,         32'd14,        34);
        do_op("REMU 100/7",     OP_REMU,   32'd100,       32'd7,         32'd2,         34);

        // special cases
        do_op("DIVU 100/0",     OP_DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF, 1);
        do_op("REM 100/0",      OP_REM,    32'd100,       32'd0,         32'h0000_0064, 1);
        do_op("DIV ovf",        OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("REM ovf",        OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        do_op("DIVU 100/7 b",   OP_DIVU,   32'd100,       32'd7,         32'd14,        34);

        // flush during the acceptance cycle: nothing starts
        bus.op = OP_MUL; bus.a = 32'd3; bus.b = 32'd5;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        #1;
        check("flush@accept stall", {31'b0, bus.stall}, 32'h0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        #1;
        check("flush@accept busy",   {31'b0, bus.busy}, 32'h0);
        check("flush@accept result", bus.result,        last_exp);
        @(negedge clk);

        // flush at counter 10
        bus.op = OP_DIVU; bus.a = 32'd1000; bus.b = 32'd3;
        bus.start = 1'b1;
        repeat (11) @(negedge clk);
        bus.flush = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check("flush busy",   {31'b0, bus.busy},  32'h0);
        check("flush stall",  {31'b0, bus.stall}, 32'h0);
        check("flush done",   {31'b0, bus.done},  32'h0);
        check("flush result", bus.result,         last_exp);
        @(negedge clk);
        do_op("REMU after flush", OP_REMU, 32'd100, 32'd7, 32'd2, 34);

        // reset at counter 10
        bus.op = OP_MULHU; bus.a = 32'h1234_5678; bus.b = 32'h9ABC_DEF0;
        bus.start = 1'b1;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst busy",   {31'b0, bus.busy},  32'h0);
        check("rst done",   {31'b0, bus.done},  32'h0);
        check("rst result", bus.result,         32'h0);
        @(negedge clk);
        do_op("MUL after rst", OP_MUL, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_ex_muldiv
`default_nettype wire

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the forwarded rs1/rs2 operands and the M-extension op of the instruction held in ID/EX. It computes the 32-bit result over multiple cycles and raises `stall` so hazard control holds IF/ID and ID/EX (`we`=0) and bubbles EX/MEM until the result is ready. On the release cycle the result is muxed into the EX result path.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous abort of any in-flight operation (exception/redirect).
- `start`  in  1  EX holds a valid M-op (decoded from ALUOp); level, held while `stall`=1.
- `op`  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `a`  in  32  rs1 operand after forwarding mux.
- `b`  in  32  rs2 operand after forwarding mux.
- `stall`  out  1  freeze front of pipe; combinational.
- `busy`  out  1  FSM not in IDLE; registered.
- `done`  out  1  one-cycle pulse, `result` valid.
- `result`  out  32  last completed result; held until the next accepted start.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - `start`=1 latches `op`, `a`, `b`.
  - Latches operand magnitudes and result sign. MULH/DIV/REM: both operands signed. MULHSU: `a` signed only. Others: unsigned.
  - Clears the 5-bit counter, then goes to CALC.
- Special cases are detected in IDLE and go straight to DONE with `result` preloaded:
  - Divide by zero (b=0, ops 4–7): quotient 0xFFFFFFFF, remainder = `a`.
  - Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): quotient 0x80000000, remainder 0.
- CALC: one step per cycle, 32 cycles (counter 0..31), then FIX.
  - Multiply: shift-add on magnitudes into a 64-bit accumulator.
  - Divide: restoring division on magnitudes; 33-bit partial remainder, 32-bit quotient.
- FIX:
  - Apply the two's-complement sign. Product sign = sign(a) XOR sign(b). Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
  - Select the word: MUL low[31:0]; MULH/MULHSU/MULHU high[63:32]; DIV/DIVU quotient; REM/REMU remainder.
  - Write `result`, go to DONE.
- DONE: `done`=1 and `stall`=0, so the pipe advances. Go to IDLE unconditionally. `start` is ignored here because it still reflects the finishing instruction.
- `stall` = (IDLE & `start` & !`flush`) | CALC | FIX.
- `busy` = (state != IDLE).
- `flush` or `rst` in any state: go to IDLE next edge, no `done` pulse, counter cleared. `rst` also clears `result`; `flush` leaves it unchanged.
- If `rst` and `flush` are asserted together, `rst` wins.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `result` 0x00000000, `stall` 0 (with `start`=0).
- Normal op:
  - Start accepted at edge E0; CALC occupies E0..E31; FIX at E32; DONE in the cycle after E33.
  - `stall` is high for 34 cycles: the acceptance cycle plus 33.
  - `done` rises 34 cycles after the `start` cycle.
- Special case: `stall` is high for 1 cycle; `done` is asserted in the next cycle.
- Back-to-back M-ops: the second `start` is accepted in the IDLE cycle right after DONE, with no dead cycle beyond DONE.
- `flush` in the acceptance cycle wins: no start, `stall` is 0.

## Structure
- Package `ex_muldiv_pkg`:
  - funct3 op constants `OP_MUL`..`OP_REMU`.
  - State enum `muldiv_state_t`.
  - `XLEN`, and the counter width 5.
  - Special-case constants `DIV0_Q` = 0xFFFFFFFF, `INT_MIN` = 0x80000000.
- Sub-module `muldiv_core`: the per-iteration datapath (accumulator/partial remainder, shift, add/subtract step).
- The top level owns the FSM, counter, sign pre/post-processing, special-case detection and `stall`.
- Target size: 200–300 lines of RTL in total.

## Test plan
- MUL a=7, b=0xFFFFFFFD → `result` 0xFFFFFFEB; `stall` high exactly 34 cycles; single `done` pulse.
- a=b=0xFFFFFFFF:
  - MULHU → 0xFFFFFFFE.
  - MULH → 0x00000000.
  - MULHSU → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9, b=2 → 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Divide by zero:
  - DIVU a=100, b=0 → 0xFFFFFFFF.
  - REM a=100, b=0 → 0x00000064.
  - `stall` high 1 cycle, `done` on the next cycle.
- Overflow: DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM with the same operands → 0; 1-cycle stall.
- Abort mid-CALC:
  - `flush` at counter 10 → IDLE next edge; `busy`/`stall` 0; no `done`; `result` keeps its prior value.
  - `rst` at the same point → `result` 0.
  - A new `start` on the following cycle completes correctly.
